// File: rtl/dino_renderer.sv
// Pixel compositor for the dino game: aligns VGA timing with the one-cycle-late
// sprite bits, merges them by priority, and produces the frame tick and collision flag.
module dino_renderer #(
  parameter logic [7:0] GROUND_Y   = 8'd200,
  parameter int         BLINK_LOG2 = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       hsync_i,
  input  logic       vsync_i,
  input  logic       visible_i,
  input  logic [8:0] position_x_i,
  input  logic [7:0] position_y_i,
  input  logic [1:0] state_i,
  input  logic       dino_pixel_i,
  input  logic       cactus_pixel_i,
  input  logic       bird_pixel_i,
  output logic [3:0] vga_red_o,
  output logic [3:0] vga_green_o,
  output logic [3:0] vga_blue_o,
  output logic       vga_hsync_o,
  output logic       vga_vsync_o,
  output logic       next_frame_o,
  output logic       hit_o
);

  typedef enum logic [1:0] {
    GS_TITLE   = 2'd0,
    GS_RUNNING = 2'd1,
    GS_HIT     = 2'd2,
    GS_TITLE_B = 2'd3
  } game_state_e;

  // Column is only consumed by the sprite modules; nothing here depends on it.
  logic unused_position_x;
  assign unused_position_x = ^position_x_i;

  // Stage 1: timing aligned with the sprite bits.
  logic hsync_s1_q;
  logic vsync_s1_q;
  logic visible_s1_q;
  logic ground_s1_q;

  // Stage 2: output registers and frame bookkeeping.
  logic [3:0]          red_q, green_q, blue_q;
  logic                hsync_s2_q;
  logic                vsync_s2_q;
  logic                vsync_prev_q;
  logic                next_frame_q;
  logic                hit_q;
  logic [BLINK_LOG2:0] blink_cnt_q;

  logic                blink_q;
  logic                in_running;
  logic                in_hit;
  logic                overlap;
  logic [3:0]          red_d, green_d, blue_d;
  logic                hit_d;
  logic [BLINK_LOG2:0] blink_cnt_d;

  assign blink_q    = blink_cnt_q[BLINK_LOG2];
  assign in_running = (game_state_e'(state_i) == GS_RUNNING);
  assign in_hit     = (game_state_e'(state_i) == GS_HIT);
  assign overlap    = visible_s1_q & dino_pixel_i & (cactus_pixel_i | bird_pixel_i);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hsync_s1_q   <= 1'b1;
      vsync_s1_q   <= 1'b1;
      visible_s1_q <= 1'b0;
      ground_s1_q  <= 1'b0;
    end else begin
      hsync_s1_q   <= hsync_i;
      vsync_s1_q   <= vsync_i;
      visible_s1_q <= visible_i;
      ground_s1_q  <= (position_y_i == GROUND_Y);
    end
  end

  // Priority: blanking, dino, bird, cactus, ground line, background.
  always_comb begin
    red_d   = 4'h0;
    green_d = 4'h0;
    blue_d  = 4'h0;
    if (!visible_s1_q) begin
      red_d   = 4'h0;
    end else if (dino_pixel_i) begin
      if (in_hit && blink_q) begin
        red_d = 4'hF;
      end else begin
        red_d   = 4'h5;
        green_d = 4'h5;
        blue_d  = 4'h5;
      end
    end else if (bird_pixel_i || cactus_pixel_i) begin
      red_d   = 4'h5;
      green_d = 4'h5;
      blue_d  = 4'h5;
    end else if (ground_s1_q) begin
      red_d   = 4'h8;
      green_d = 4'h8;
      blue_d  = 4'h8;
    end else begin
      red_d   = 4'hF;
      green_d = 4'hF;
      blue_d  = 4'hF;
    end
  end

  // Leaving RUNNING clears the flag even if an overlap is seen in the same cycle.
  always_comb begin
    hit_d = hit_q;
    if (!in_running) begin
      hit_d = 1'b0;
    end else if (overlap) begin
      hit_d = 1'b1;
    end
  end

  always_comb begin
    blink_cnt_d = '0;
    if (in_hit) begin
      blink_cnt_d = next_frame_q ? blink_cnt_q + 1'b1 : blink_cnt_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      red_q        <= 4'h0;
      green_q      <= 4'h0;
      blue_q       <= 4'h0;
      hsync_s2_q   <= 1'b1;
      vsync_s2_q   <= 1'b1;
      vsync_prev_q <= 1'b1;
      next_frame_q <= 1'b0;
      hit_q        <= 1'b0;
      blink_cnt_q  <= '0;
    end else begin
      red_q        <= red_d;
      green_q      <= green_d;
      blue_q       <= blue_d;
      hsync_s2_q   <= hsync_s1_q;
      vsync_s2_q   <= vsync_s1_q;
      vsync_prev_q <= vsync_s1_q;
      next_frame_q <= vsync_prev_q & ~vsync_s1_q;
      hit_q        <= hit_d;
      blink_cnt_q  <= blink_cnt_d;
    end
  end

  assign vga_red_o    = red_q;
  assign vga_green_o  = green_q;
  assign vga_blue_o   = blue_q;
  assign vga_hsync_o  = hsync_s2_q;
  assign vga_vsync_o  = vsync_s2_q;
  assign next_frame_o = next_frame_q;
  assign hit_o        = hit_q;

endmodule

// File: tb/tb_dino_renderer.sv
// Bench for dino_renderer: directed scenarios plus random traffic, all compared
// against a cycle-level behavioural model of the compositor.
module tb_dino_renderer;

  localparam int FRAMES_PER_PHASE = 16;
  localparam int CYCLE_FRAMES     = 32;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       hsync_i = 1'b1;
  logic       vsync_i = 1'b1;
  logic       visible_i = 1'b0;
  logic [8:0] position_x_i = '0;
  logic [7:0] position_y_i = '0;
  logic [1:0] state_i = 2'd0;
  logic       dino_pixel_i = 1'b0;
  logic       cactus_pixel_i = 1'b0;
  logic       bird_pixel_i = 1'b0;
  logic [3:0] vga_red_o, vga_green_o, vga_blue_o;
  logic       vga_hsync_o, vga_vsync_o, next_frame_o, hit_o;

  int errors = 0;
  int checks = 0;

  dino_renderer #(.GROUND_Y(8'd200), .BLINK_LOG2(4)) dut (
    .clk_i(clk), .rst_i(rst),
    .hsync_i(hsync_i), .vsync_i(vsync_i), .visible_i(visible_i),
    .position_x_i(position_x_i), .position_y_i(position_y_i), .state_i(state_i),
    .dino_pixel_i(dino_pixel_i), .cactus_pixel_i(cactus_pixel_i), .bird_pixel_i(bird_pixel_i),
    .vga_red_o(vga_red_o), .vga_green_o(vga_green_o), .vga_blue_o(vga_blue_o),
    .vga_hsync_o(vga_hsync_o), .vga_vsync_o(vga_vsync_o),
    .next_frame_o(next_frame_o), .hit_o(hit_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Tracks what the position of one cycle ago looked like, combines it with the
  // sprite bits arriving now, and counts HIT frames as a plain integer.
  logic [11:0] m_rgb;
  logic        m_hs, m_vs, m_nf, m_hit;
  logic        m_p_hs, m_p_vs, m_p_vis, m_vs_old;
  int          m_p_y;
  int          m_frames;

  always @(posedge clk or posedge rst) begin
    int  st;
    logic blink, new_nf;
    if (rst) begin
      m_rgb = 12'h000; m_hs = 1'b1; m_vs = 1'b1; m_nf = 1'b0; m_hit = 1'b0;
      m_p_hs = 1'b1; m_p_vs = 1'b1; m_p_vis = 1'b0; m_vs_old = 1'b1;
      m_p_y = 0; m_frames = 0;
    end else begin
      st = (state_i == 2'd3) ? 0 : int'(state_i);
      blink = ((m_frames / FRAMES_PER_PHASE) % 2) == 1;
      if (!m_p_vis) m_rgb = 12'h000;
      else if (dino_pixel_i) m_rgb = (st == 2 && blink) ? 12'hF00 : 12'h555;
      else if (bird_pixel_i || cactus_pixel_i) m_rgb = 12'h555;
      else if (m_p_y == 200) m_rgb = 12'h888;
      else m_rgb = 12'hFFF;
      if (st != 1) m_hit = 1'b0;
      else if (m_p_vis && dino_pixel_i && (bird_pixel_i || cactus_pixel_i)) m_hit = 1'b1;
      if (st != 2) m_frames = 0;
      else if (m_nf) m_frames = (m_frames + 1) % CYCLE_FRAMES;
      new_nf = m_vs_old && !m_p_vs;
      m_nf = new_nf;
      m_hs = m_p_hs;
      m_vs = m_p_vs;
      m_vs_old = m_p_vs;
      m_p_hs = hsync_i; m_p_vs = vsync_i; m_p_vis = visible_i; m_p_y = int'(position_y_i);
    end
  end

  logic [15:0] exp_word, dut_word;
  assign exp_word = {m_rgb, m_hs, m_vs, m_nf, m_hit};
  assign dut_word = {vga_red_o, vga_green_o, vga_blue_o, vga_hsync_o, vga_vsync_o, next_frame_o, hit_o};

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_sprites(input logic d, input logic c, input logic b);
    dino_pixel_i = d; cactus_pixel_i = c; bird_pixel_i = b;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      hsync_i = 1'($urandom); vsync_i = 1'($urandom); visible_i = 1'($urandom);
      position_y_i = 8'($urandom); state_i = 2'($urandom);
      set_sprites(1'($urandom), 1'($urandom), 1'($urandom));
      tick();
      checks++;
      if (dut_word !== 16'h000C) begin
        errors++;
        $display("FAIL reset_hold cyc%0d: got %h expected %h", i, dut_word, 16'h000C);
      end
    end
    vsync_i = 1'b1; hsync_i = 1'b1; visible_i = 1'b0; state_i = 2'd0;
    set_sprites(0, 0, 0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (next_frame_o !== 1'b0 || dut_word !== exp_word) begin
        errors++;
        $display("FAIL reset_release cyc%0d: got %h expected %h (next_frame must be 0)", i, dut_word, exp_word);
      end
    end
  endtask

  task automatic test_priority();
    logic [11:0] want;
    state_i = 2'd1;
    for (int i = 0; i < 5; i++) begin
      position_x_i = 9'd100;
      position_y_i = (i == 2) ? 8'd200 : (i == 3) ? 8'd10 : 8'd50;
      visible_i = (i != 4);
      set_sprites(0, 0, 0);
      tick();
      case (i)
        0: begin set_sprites(1, 1, 1); want = 12'h555; end
        1: begin set_sprites(0, 1, 0); want = 12'h555; end
        2: begin set_sprites(0, 0, 0); want = 12'h888; end
        3: begin set_sprites(0, 0, 0); want = 12'hFFF; end
        default: begin set_sprites(1, 1, 1); want = 12'h000; end
      endcase
      visible_i = 1'b0;
      tick();
      checks++;
      if ({vga_red_o, vga_green_o, vga_blue_o} !== want || dut_word !== exp_word) begin
        errors++;
        $display("FAIL priority case%0d: got rgb %h word %h expected rgb %h word %h",
                 i, {vga_red_o, vga_green_o, vga_blue_o}, dut_word, want, exp_word);
      end
    end
    set_sprites(0, 0, 0);
  endtask

  task automatic test_collision();
    state_i = 2'd0; visible_i = 1'b0; set_sprites(0, 0, 0);
    tick();
    state_i = 2'd1; visible_i = 1'b1; position_y_i = 8'd60;
    tick();
    set_sprites(1, 0, 1); visible_i = 1'b0;
    tick();
    checks++;
    if (hit_o !== 1'b1) begin errors++; $display("FAIL collision_set: got %b expected 1", hit_o); end
    set_sprites(0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (hit_o !== 1'b1 || dut_word !== exp_word) begin
        errors++;
        $display("FAIL collision_hold cyc%0d: got %h expected %h", i, dut_word, exp_word);
      end
    end
    state_i = 2'd2;
    tick();
    checks++;
    if (hit_o !== 1'b0) begin errors++; $display("FAIL collision_clear: got %b expected 0", hit_o); end
    state_i = 2'd0; visible_i = 1'b1;
    tick();
    set_sprites(1, 1, 1); visible_i = 1'b0;
    tick();
    set_sprites(0, 0, 0);
    tick();
    checks++;
    if (hit_o !== 1'b0 || dut_word !== exp_word) begin
      errors++;
      $display("FAIL collision_title: got %h expected %h (hit must stay 0)", dut_word, exp_word);
    end
  endtask

  task automatic test_frame_tick();
    int pulses = 0;
    int at0 = -1, at1 = -1;
    state_i = 2'd1; vsync_i = 1'b1; visible_i = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    for (int n = 0; n < 2100; n++) begin
      vsync_i = !((n < 500) || (n >= 1000));
      tick();
      if (next_frame_o === 1'b1) begin
        if (pulses == 0) at0 = n; else if (pulses == 1) at1 = n;
        pulses++;
      end
      checks++;
      if (dut_word !== exp_word) begin
        errors++;
        $display("FAIL frame_tick cyc%0d: got %h expected %h", n, dut_word, exp_word);
      end
    end
    checks++;
    if (pulses != 2 || at0 != 1 || at1 != 1001) begin
      errors++;
      $display("FAIL frame_tick_count: got %0d pulses at %0d,%0d expected 2 at 1,1001", pulses, at0, at1);
    end
    vsync_i = 1'b1;
    for (int i = 0; i < 3; i++) tick();
  endtask

  task automatic blink_frame();
    for (int c = 0; c < 8; c++) begin
      vsync_i = (c >= 2);
      tick();
      checks++;
      if (dut_word !== exp_word) begin
        errors++;
        $display("FAIL blink_cycle: got %h expected %h", dut_word, exp_word);
      end
    end
  endtask

  task automatic test_blink();
    logic [11:0] want;
    vsync_i = 1'b1; state_i = 2'd0; visible_i = 1'b1; position_y_i = 8'd10;
    set_sprites(1, 0, 0);
    tick(); tick();
    state_i = 2'd2;
    tick(); tick();
    for (int f = 0; f <= 48; f++) begin
      if (f > 0) blink_frame();
      want = ((f % 32) < 16) ? 12'h555 : 12'hF00;
      checks++;
      if ({vga_red_o, vga_green_o, vga_blue_o} !== want) begin
        errors++;
        $display("FAIL blink frame%0d: got %h expected %h", f, {vga_red_o, vga_green_o, vga_blue_o}, want);
      end
    end
    state_i = 2'd0;
    tick();
    state_i = 2'd2;
    tick(); tick();
    checks++;
    if ({vga_red_o, vga_green_o, vga_blue_o} !== 12'h555 || dut_word !== exp_word) begin
      errors++;
      $display("FAIL blink_restart: got %h expected rgb 555 word %h", dut_word, exp_word);
    end
    set_sprites(0, 0, 0);
  endtask

  task automatic test_async_reset();
    state_i = 2'd0; tick();
    state_i = 2'd1; visible_i = 1'b1; position_y_i = 8'd40; vsync_i = 1'b1;
    tick();
    set_sprites(1, 1, 0);
    tick();
    checks++;
    if (hit_o !== 1'b1 || {vga_red_o, vga_green_o, vga_blue_o} !== 12'h555) begin
      errors++;
      $display("FAIL async_pre: got hit %b rgb %h expected hit 1 rgb 555", hit_o, {vga_red_o, vga_green_o, vga_blue_o});
    end
    #3 rst = 1'b1;
    #1;
    checks++;
    if (dut_word !== 16'h000C) begin
      errors++;
      $display("FAIL async_reset: got %h expected %h", dut_word, 16'h000C);
    end
    set_sprites(0, 0, 0); visible_i = 1'b0; vsync_i = 1'b1;
    tick();
    #4 rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (next_frame_o !== 1'b0 || dut_word !== exp_word) begin
        errors++;
        $display("FAIL async_release cyc%0d: got %h expected %h", i, dut_word, exp_word);
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 1500; n++) begin
      hsync_i = ($urandom_range(0, 7) != 0);
      vsync_i = ($urandom_range(0, 9) != 0);
      visible_i = 1'($urandom);
      position_x_i = 9'($urandom_range(0, 511));
      position_y_i = ($urandom_range(0, 3) == 0) ? 8'd200 : 8'($urandom);
      state_i = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'd1;
      set_sprites(1'($urandom), 1'($urandom), 1'($urandom));
      tick();
      checks++;
      if (dut_word !== exp_word) begin
        errors++;
        $display("FAIL random cyc%0d: got %h expected %h", n, dut_word, exp_word);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_priority();
    test_collision();
    test_frame_tick();
    test_blink();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
